game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_pkg.sv | 28 ++
 rtl/lane_timer.sv | 41 ++++
 rtl/game_sequencer.sv | 97 +++++++++
 tb/tb_game_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: FSM encoding, defaults, period helper.
package game_pkg;

  localparam int unsigned N_LANES_DEF  = 11;
  localparam int unsigned GOAL_ROW_DEF = 1;
  localparam int unsigned LEVEL_MAX    = 99;
  localparam int unsigned LEVEL_W      = 7;
  localparam int unsigned PERIOD_W     = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_HIT   = 2'd2,
    S_LEVEL = 2'd3
  } state_e;

  // Step period for one lane: base minus slowdown terms, floored at min_p (never wraps).
  function automatic logic [PERIOD_W-1:0] lane_period(input int unsigned base,
                                                      input int unsigned min_p,
                                                      input int unsigned slow,
                                                      input int unsigned lane);
    int unsigned dec;
    dec = slow + lane;
    if (dec + min_p >= base) return PERIOD_W'(min_p);
    return PERIOD_W'(base - dec);
  endfunction

endpackage

// File: rtl/lane_timer.sv
// One lane's frame counter: counts enabled frames, ticks one cycle after reaching its period.
module lane_timer
  import game_pkg::*;
(
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_tick
);

  localparam int unsigned CW = PERIOD_W + 1;

  logic [PERIOD_W-1:0] cnt;
  logic                reached_c;

  // A counter left above a freshly shrunk period still counts as reached.
  assign reached_c = (CW'(cnt) + CW'(1)) >= CW'(i_period);

  // Counter and registered tick pulse.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= 1'b0;
      if (i_clr) begin
        cnt <= '0;
      end else if (i_en) begin
        if (reached_c) begin
          cnt    <= '0;
          o_tick <= 1'b1;
        end else begin
          cnt <= cnt + PERIOD_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: play/hit/level FSM plus per-lane car step timers.
// Optional build macro GAME_SPEEDUP_EN shortens lane periods as the level rises.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned N_LANES     = N_LANES_DEF,
  parameter int unsigned BASE_PERIOD = 30,
  parameter int unsigned MIN_PERIOD  = 4,
  parameter int unsigned HIT_FRAMES  = 60,
  parameter int unsigned GOAL_ROW    = GOAL_ROW_DEF
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_frame_start,
  input  logic               i_collision,
  input  logic [3:0]         i_player_y,
  output logic [N_LANES-1:0] o_lane_tick,
  output logic               o_player_reset,
  output logic [LEVEL_W-1:0] o_level,
  output logic [1:0]         o_state
);

  localparam int unsigned HIT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

  state_e             state;
  logic [HIT_W-1:0]   hit_cnt;
  logic               goal_c;
  logic               lane_en_c;
  logic               lane_clr_c;
  logic [LEVEL_W-1:0] level_inc_c;

  assign goal_c      = (i_player_y == 4'(GOAL_ROW));
  // Lanes only advance on frames that keep the game in play, so a tick never
  // coincides with the player-reset pulse of a hit or level-up.
  assign lane_en_c   = i_frame_start && (state == S_PLAY) && !i_collision && !goal_c;
  assign lane_clr_c  = i_frame_start && (state == S_PLAY) && !i_collision && goal_c;
  assign level_inc_c = (o_level == LEVEL_W'(LEVEL_MAX)) ? '0 : o_level + LEVEL_W'(1);
  assign o_state     = state;

  // Game FSM with registered level and player-reset outputs; moves only on frame starts.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state          <= S_IDLE;
      o_level        <= '0;
      o_player_reset <= 1'b0;
      hit_cnt        <= '0;
    end else begin
      o_player_reset <= 1'b0;
      if (i_frame_start) begin
        case (state)
          S_IDLE: state <= S_PLAY;
          S_PLAY: begin
            if (i_collision) begin
              state          <= S_HIT;
              o_level        <= '0;
              hit_cnt        <= '0;
              o_player_reset <= 1'b1;
            end else if (goal_c) begin
              state          <= S_LEVEL;
              o_level        <= level_inc_c;
              o_player_reset <= 1'b1;
            end
          end
          S_HIT: begin
            if (hit_cnt == HIT_W'(HIT_FRAMES - 1)) begin
              state   <= S_PLAY;
              hit_cnt <= '0;
            end else begin
              hit_cnt <= hit_cnt + HIT_W'(1);
            end
          end
          S_LEVEL: state <= S_PLAY;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // One timer per lane; lane k runs k frames faster than the base period.
  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic [PERIOD_W-1:0] period_c;
`ifdef GAME_SPEEDUP_EN
    assign period_c = lane_period(BASE_PERIOD, MIN_PERIOD, 32'(o_level >> 2), 32'(k));
`else
    assign period_c = lane_period(BASE_PERIOD, MIN_PERIOD, 0, 32'(k));
`endif
    lane_timer u_lane_timer (
      .i_Clk    (i_Clk),
      .i_Rst_n  (i_Rst_n),
      .i_en     (lane_en_c),
      .i_clr    (lane_clr_c),
      .i_period (period_c),
      .o_tick   (o_lane_tick[k])
    );
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus queues expected pulses, monitor checks them.
module tb_game_sequencer;
  import game_pkg::*;

  localparam int unsigned NL = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fs = 1'b0;
  logic          coll = 1'b0;
  logic [3:0]    py = 4'd8;
  logic [NL-1:0] o_lane_tick;
  logic          o_player_reset;
  logic [6:0]    o_level;
  logic [1:0]    o_state;

  typedef struct packed {
    logic [NL-1:0] tick;
    logic          prst;
    logic [6:0]    level;
    logic [1:0]    state;
  } ev_t;

  ev_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  f = 0;
  int  lvl = 0;

  // Hand-computed periods: level 0 is 30-k; the speedup build at level 96 is max(4, 6-k).
  int per_lo[NL] = '{30, 29, 28, 27, 26, 25, 24, 23, 22, 21, 20};
`ifdef GAME_SPEEDUP_EN
  int per_hi[NL] = '{6, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4};
`else
  int per_hi[NL] = '{30, 29, 28, 27, 26, 25, 24, 23, 22, 21, 20};
`endif

  game_sequencer dut (
    .i_Clk          (clk),
    .i_Rst_n        (rst_n),
    .i_frame_start  (fs),
    .i_collision    (coll),
    .i_player_y     (py),
    .o_lane_tick    (o_lane_tick),
    .o_player_reset (o_player_reset),
    .o_level        (o_level),
    .o_state        (o_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NL-1:0] exp_ticks(input int fr, input logic hi);
    logic [NL-1:0] v;
    for (int k = 0; k < NL; k++) v[k] = ((fr % (hi ? per_hi[k] : per_lo[k])) == 0);
    return v;
  endfunction

  // Monitor: every visible pulse must match the oldest expected event.
  always @(negedge clk) begin : mon
    ev_t got;
    ev_t exp;
    if (rst_n && (o_lane_tick != '0 || o_player_reset)) begin
      got = '{tick: o_lane_tick, prst: o_player_reset, level: o_level, state: o_state};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %0h expected none", got);
      end else begin
        exp = sb.pop_front();
        chk("event", 32'(got), 32'(exp));
      end
    end
  end

  task automatic frame(input logic c, input logic [3:0] y);
    @(negedge clk);
    coll = c;
    py   = y;
    fs   = 1'b1;
    @(negedge clk);
    fs   = 1'b0;
    coll = 1'b0;
    py   = 4'd8;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic play(input int n, input logic hi);
    logic [NL-1:0] e;
    for (int i = 0; i < n; i++) begin
      f++;
      e = exp_ticks(f, hi);
      if (e != '0) sb.push_back('{tick: e, prst: 1'b0, level: 7'(lvl), state: 2'(S_PLAY)});
      frame(1'b0, 4'd8);
    end
  endtask

  task automatic level_up();
    lvl = (lvl == 99) ? 0 : lvl + 1;
    sb.push_back('{tick: '0, prst: 1'b1, level: 7'(lvl), state: 2'(S_LEVEL)});
    frame(1'b0, 4'd1);
    f = 0;
    frame(1'b0, 4'd8);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(o_state), 32'(S_IDLE));
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_tick", 32'(o_lane_tick), 32'd0);
    chk("rst_prst", 32'(o_player_reset), 32'd0);
    rst_n = 1'b1;

    // Idle to play, then lanes run from zero.
    frame(1'b0, 4'd8);
    chk("idle_to_play", 32'(o_state), 32'(S_PLAY));
    play(2, 1'b0);
    chk("play_level0", 32'(o_level), 32'd0);
    play(38, 1'b0);
    chk("drain_play", 32'(sb.size()), 32'd0);

    // Collision wins over goal row; game freezes for 60 frames.
    sb.push_back('{tick: '0, prst: 1'b1, level: 7'd0, state: 2'(S_HIT)});
    frame(1'b1, 4'd1);
    chk("hit_entry", 32'(o_state), 32'(S_HIT));
    repeat (59) frame(1'b0, 4'd8);
    chk("hit_hold", 32'(o_state), 32'(S_HIT));
    frame(1'b0, 4'd8);
    chk("hit_exit", 32'(o_state), 32'(S_PLAY));
    play(5, 1'b0);
    chk("drain_hit", 32'(sb.size()), 32'd0);

    // Climb to level 96 and run the lanes there.
    for (int l = 0; l < 96; l++) level_up();
    chk("level96", 32'(o_level), 32'd96);
    chk("level96_state", 32'(o_state), 32'(S_PLAY));
    play(12, 1'b1);
    chk("drain_l96", 32'(sb.size()), 32'd0);

    // 97, 98, 99, then wrap to 0.
    repeat (3) level_up();
    chk("level99", 32'(o_level), 32'd99);
    lvl = 0;
    sb.push_back('{tick: '0, prst: 1'b1, level: 7'd0, state: 2'(S_LEVEL)});
    frame(1'b0, 4'd1);
    chk("wrap_state", 32'(o_state), 32'(S_LEVEL));
    chk("wrap_level", 32'(o_level), 32'd0);
    frame(1'b0, 4'd8);
    chk("wrap_play", 32'(o_state), 32'(S_PLAY));
    chk("drain_wrap", 32'(sb.size()), 32'd0);

    // Reset in the middle of a hit freeze.
    sb.push_back('{tick: '0, prst: 1'b1, level: 7'd0, state: 2'(S_HIT)});
    frame(1'b1, 4'd8);
    repeat (30) frame(1'b0, 4'd8);
    chk("pre_rst_hit", 32'(o_state), 32'(S_HIT));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(o_state), 32'(S_IDLE));
    chk("mid_rst_level", 32'(o_level), 32'd0);
    chk("mid_rst_tick", 32'(o_lane_tick), 32'd0);
    chk("mid_rst_prst", 32'(o_player_reset), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", 32'(o_state), 32'(S_IDLE));
    frame(1'b0, 4'd8);
    chk("post_rst_play", 32'(o_state), 32'(S_PLAY));
    lvl = 0;
    f = 0;
    play(25, 1'b0);
    chk("drain_end", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
